// File: rtl/sw_in_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_in_pkg
// Description : Shared types and helpers for the switch input port.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_in_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int unsigned MIN_PKT_LEN = 2;

    // Pointers carry one extra wrap bit, so the masked difference is the occupancy.
    function automatic logic [31:0] free_space(
        input logic [31:0] depth,
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr
    );
        logic [31:0] used;
        used = (wr_ptr - rd_ptr) & ((depth << 1) - 32'd1);
        return depth - used;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sw_pkt_fifo
// Description : Packet FIFO with speculative write, commit, rewind and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_pkt_fifo
    import sw_in_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  commit,
    input  logic                  rewind,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [$clog2(DEPTH):0] free_now,
    output logic [$clog2(DEPTH):0] free_next
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned c_IDX_W = c_PTR_W - 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_cmt_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_wr_next;
    logic [c_PTR_W-1:0] w_cmt_next;
    logic [c_PTR_W-1:0] w_rd_next;

    always_comb begin
        w_wr_next  = r_wr_ptr;
        w_cmt_next = r_cmt_ptr;
        w_rd_next  = r_rd_ptr;
        if (rewind) begin
            w_wr_next = r_cmt_ptr;
        end else if (wr_en) begin
            w_wr_next = r_wr_ptr + c_PTR_W'(1);
        end
        // Committing takes the post-write pointer so the final word is included.
        if (commit) begin
            w_cmt_next = w_wr_next;
        end
        if (pop) begin
            w_rd_next = r_rd_ptr + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_wr_ptr  <= w_wr_next;
            r_cmt_ptr <= w_cmt_next;
            r_rd_ptr  <= w_rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rewind) begin
            r_mem[r_wr_ptr[c_IDX_W-1:0]] <= wr_data;
        end
    end

    assign rd_valid  = (r_rd_ptr != r_cmt_ptr);
    assign rd_data   = rd_valid ? r_mem[r_rd_ptr[c_IDX_W-1:0]] : '0;
    assign free_now  = c_PTR_W'(free_space(32'(DEPTH), 32'(r_wr_ptr), 32'(r_rd_ptr)));
    assign free_next = c_PTR_W'(free_space(32'(DEPTH), 32'(w_wr_next), 32'(w_rd_next)));

endmodule
`default_nettype wire

// File: rtl/sw_input_port.sv
`default_nettype none
// ============================================================================
// Module      : sw_input_port
// Description : Switch ingress port: frames enable bursts into packets,
//               drops bad ones, and streams committed packets to the fabric.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_input_port
    import sw_in_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned MAX_PKT_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sw_enable_in,
    output logic              read_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop_pulse,
    output logic [15:0]       pkt_count
);

    localparam int unsigned c_PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned c_LEN_W = $clog2(MAX_PKT_LEN + 1);

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_stage_data;
    logic               r_stage_sop;
    logic [c_LEN_W-1:0] r_len;
    logic [c_LEN_W-1:0] w_len_next;
    logic               r_read_out;
    logic               r_drop_pulse;
    logic [15:0]        r_pkt_count;
    logic               w_wr_en;
    logic               w_wr_eop;
    logic               w_commit;
    logic               w_rewind;
    logic               w_stage_load;
    logic               w_drop;
    logic               w_pop;
    logic               w_rd_valid;
    fifo_entry_t        w_wr_entry;
    fifo_entry_t        w_rd_entry;
    logic [c_PTR_W-1:0] w_free_now;
    logic [c_PTR_W-1:0] w_free_next;

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_wr_en      = 1'b0;
        w_wr_eop     = 1'b0;
        w_commit     = 1'b0;
        w_rewind     = 1'b0;
        w_stage_load = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (sw_enable_in) begin
                    if (r_read_out) begin
                        w_state_next = DROP;
                    end else begin
                        w_state_next = RECV;
                        w_stage_load = 1'b1;
                        w_len_next   = c_LEN_W'(1);
                    end
                end
            end
            RECV: begin
                if (sw_enable_in) begin
                    if (r_len == c_LEN_W'(MAX_PKT_LEN) || w_free_now == '0) begin
                        w_rewind     = 1'b1;
                        w_state_next = DROP;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_stage_load = 1'b1;
                        w_len_next   = r_len + c_LEN_W'(1);
                    end
                end else if (r_len >= c_LEN_W'(MIN_PKT_LEN)) begin
                    w_wr_en      = 1'b1;
                    w_wr_eop     = 1'b1;
                    w_commit     = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_rewind     = 1'b1;
                    w_drop       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            DROP: begin
                if (!sw_enable_in) begin
                    w_drop       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The staged word is held back one cycle so its eop bit is known when written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_stage_data <= '0;
            r_stage_sop  <= 1'b0;
            r_len        <= '0;
            r_read_out   <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_len        <= w_len_next;
            r_drop_pulse <= w_drop;
            r_read_out   <= (w_state_next != IDLE) || (32'(w_free_next) < MAX_PKT_LEN);
            if (w_stage_load) begin
                r_stage_data <= data_in;
                r_stage_sop  <= (r_state == IDLE);
            end
            if (w_commit) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign w_wr_entry = '{sop: r_stage_sop, eop: w_wr_eop, data: r_stage_data};
    assign w_pop      = w_rd_valid && out_ready;

    sw_pkt_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_wr_en),
        .wr_data   (w_wr_entry),
        .commit    (w_commit),
        .rewind    (w_rewind),
        .pop       (w_pop),
        .rd_data   (w_rd_entry),
        .rd_valid  (w_rd_valid),
        .free_now  (w_free_now),
        .free_next (w_free_next)
    );

    assign read_out   = r_read_out;
    assign out_valid  = w_rd_valid;
    assign out_data   = w_rd_entry.data;
    assign out_sop    = w_rd_entry.sop;
    assign out_eop    = w_rd_entry.eop;
    assign drop_pulse = r_drop_pulse;
    assign pkt_count  = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_sw_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_input_port
// Description : Randomised self-checking bench for sw_input_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_input_port;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned MAX_PKT_LEN = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] data_in;
    logic              sw_enable_in;
    logic              read_out;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_valid;
    logic              out_ready;
    logic              drop_pulse;
    logic [15:0]       pkt_count;

    sw_input_port #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .MAX_PKT_LEN (MAX_PKT_LEN)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .sw_enable_in (sw_enable_in),
        .read_out     (read_out),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .drop_pulse   (drop_pulse),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [9:0]  m_q[$];       // committed, unread beats {sop, eop, data}
    logic [7:0]  tx[$];        // packet currently being sent
    logic [15:0] m_count = '0;
    logic        m_ro = 1'b0;
    logic        m_drop = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("head_beat", 32'({out_sop, out_eop, out_data}), 32'(m_q[0]));
        chk("read_out", 32'(read_out), 32'(m_ro));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
        chk("pkt_count", 32'(pkt_count), 32'(m_count));
    endtask

    // One clock: drive inputs, advance the reference across the edge, compare.
    task automatic step(input logic en, input logic [7:0] d, input bit do_commit, input bit do_drop);
        bit pop;
        sw_enable_in = en;
        data_in      = d;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        pop = (m_q.size() > 0) && out_ready;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (do_commit) begin
            for (int i = 0; i < tx.size(); i++)
                m_q.push_back({i == 0, i == tx.size() - 1, tx[i]});
            m_count++;
        end
        m_drop = do_drop;
        m_ro   = en ? 1'b1 : ((int'(FIFO_DEPTH) - m_q.size()) < int'(MAX_PKT_LEN));
        #1;
        chk_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send();
        bit acc;
        acc = !m_ro && tx.size() >= 2 && tx.size() <= int'(MAX_PKT_LEN);
        foreach (tx[i]) step(1'b1, tx[i], 1'b0, 1'b0);
        step(1'b0, 8'h00, acc, !acc);
    endtask

    task automatic rand_pkt(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    endtask

    task automatic wait_ro();
        int budget = 2000;
        while (m_ro && budget > 0) begin
            idle(1);
            budget--;
        end
        if (budget == 0) chk("wait_read_out", 32'(read_out), 32'd0);
    endtask

    task automatic drain();
        int budget = 2000;
        while (m_q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        if (budget == 0) chk("drain", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        sw_enable_in = 1'b0;
        data_in      = '0;
        out_ready    = 1'b0;
        rst_n        = 1'b0;
        #1;
        m_q.delete();
        m_count = '0;
        m_ro    = 1'b0;
        m_drop  = 1'b0;
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sop_eop", 32'({out_sop, out_eop}), 32'd0);
        chk_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_outputs();
    endtask

    initial begin
        logic [15:0] base;
        sw_enable_in = 1'b0;
        data_in      = '0;
        out_ready    = 1'b0;
        do_reset();

        // Single 4-word packet, sink always ready
        out_ready = 1'b1;
        tx = {8'h05, 8'h01, 8'hAA, 8'hBB};
        send();
        idle(6);
        chk("t1_pkt_count", 32'(pkt_count), 32'd1);

        // Runt packet
        tx = {8'h07};
        send();
        idle(3);

        // Overlong packet followed by a good one
        rand_pkt(10);
        send();
        rand_pkt(3);
        send();
        idle(6);

        // Fill the FIFO with two maximal packets, then push a third while busy
        out_ready = 1'b0;
        rand_pkt(8);
        send();
        rand_pkt(8);
        send();
        chk("t4_busy", 32'(read_out), 32'd1);
        rand_pkt(8);
        send();
        out_ready = 1'b1;
        idle(20);

        // Reset in the middle of a packet with committed data pending
        out_ready = 1'b0;
        rand_pkt(4);
        send();
        rand_pkt(4);
        send();
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset();
        idle(4);
        out_ready = 1'b1;
        rand_pkt(3);
        send();
        idle(5);

        // Back-to-back 2-word packets against a random sink
        rand_ready = 1'b1;
        base = m_count;
        for (int p = 0; p < 200; p++) begin
            wait_ro();
            rand_pkt(2);
            send();
        end
        drain();
        chk("t6_pkt_count", 32'(pkt_count), 32'(base + 16'd200));

        // Mixed lengths, occasionally ignoring busy
        for (int p = 0; p < 100; p++) begin
            if ($urandom_range(0, 7) != 0) wait_ro();
            rand_pkt(int'($urandom_range(1, 10)));
            send();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
Parametrised ingress stage for one switch input port. It samples the serial word stream on data_in while sw_enable_in is high and frames each enable burst as one packet: word 0 is the destination, word 1 is the source, the rest is payload. Complete packets are stored in a commit/rewind FIFO and presented to the switch fabric over a valid/ready interface with sop/eop markers. It drives read_out as the busy/backpressure signal and silently drops malformed or overflowing packets.

Parameters:
DATA_W, 8, word width of data_in and out_data
FIFO_DEPTH, 16, FIFO entries; power of two, >= 4, >= MAX_PKT_LEN
MAX_PKT_LEN, 8, maximum packet length in words, header included; range 2..FIFO_DEPTH

Ports:
clk  in  1  clock; all sampling on rising edge
rst_n  in  1  asynchronous active-low reset
data_in  in  DATA_W  serial packet word
sw_enable_in  in  1  high for each valid word of a packet; low between packets
read_out  out  1  busy; sender must not start a packet while high
out_data  out  DATA_W  FIFO head word
out_sop  out  1  head word is the first word of a packet
out_eop  out  1  head word is the last word of a packet
out_valid  out  1  head word is committed and readable
out_ready  in  1  fabric accepts the head word when out_valid && out_ready
drop_pulse  out  1  one-cycle pulse per dropped packet
pkt_count  out  16  committed packets since reset; wraps at 2^16

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all pointers and counters=0; staging register empty. read_out=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, drop_pulse=0, pkt_count=0.
- FSM states: IDLE, RECV, DROP.
  - IDLE + enable high + read_out low -> RECV. Stage the word with sop=1; len=1.
  - IDLE + enable high + read_out high -> DROP.
  - RECV + enable high: write the staged word (sop, eop=0) at the speculative write pointer, stage the new word, len+1.
    - If len would exceed MAX_PKT_LEN, or the FIFO has no free entry: rewind the speculative pointer to the committed pointer and go to DROP.
  - RECV + enable low:
    - len >= 2: write the staged word with eop=1 and set committed pointer = speculative pointer + 1 on the same edge; pkt_count+1; go to IDLE.
    - len == 1 (runt): rewind, pulse drop_pulse, go to IDLE.
  - DROP: discard words while enable is high. On the first low: pulse drop_pulse, go to IDLE.
- Latency: if the last word is sampled at edge E and enable low at edge E+1, then out_valid for the packet's first word is high after E+1. This holds only if the FIFO was empty, i.e. a 2-edge minimum.
- Read side only sees committed words. out_valid = (rd_ptr != committed ptr). out_data, out_sop and out_eop are combinational from the FIFO head. Pop when out_valid && out_ready.
- Free space = FIFO_DEPTH - (speculative ptr - rd_ptr), using (log2 DEPTH)+1-bit pointers with wrap-around.
- read_out = registered (free space < MAX_PKT_LEN) while in IDLE. Forced 1 in RECV and DROP.
- Simultaneous pop and write/commit on the same edge are both honoured. A pop frees space for the next cycle's read_out.
- Back-to-back packets need at least one enable-low cycle between them. That cycle is the commit cycle.
- Reset mid-packet discards everything, including committed, unread packets.

Decomposition:
- Package sw_in_pkg holds:
  - typedef enum {IDLE, RECV, DROP} state_t
  - parametrised struct fifo_entry_t {sop, eop, data}
  - localparam MIN_PKT_LEN = 2
  - function free_space(ptrs)
- One sub-module, sw_pkt_fifo: a storage array with write/commit/rewind/pop ports and committed-count outputs. The FSM, staging register and counters stay in sw_input_port.

Test Plan:
1. Send packet 0x05,0x01,0xAA,0xBB (4 words) with out_ready=1. Required: out_valid 2 edges after the last word; 4 beats 05(sop),01,AA,BB(eop); pkt_count=1; drop_pulse never high.
2. Send a 1-word packet 0x07. Required: drop_pulse one cycle after enable falls; out_valid stays 0; pkt_count=0.
3. MAX_PKT_LEN=8, send a 10-word packet. Required: one drop_pulse when enable falls; no output beats; a following 3-word packet is delivered intact.
4. DEPTH=16, out_ready=0, send 8-word packets. Required: both the 1st and 2nd are committed; read_out stays 1 after the 2nd (free=0 < 8). A 3rd packet sent despite read_out is dropped. Raising out_ready drains 16 beats and read_out falls once free >= 8.
5. Assert rst_n low in the middle of packet 3 while packets 1 and 2 are committed. Required: all outputs and pkt_count are 0 immediately; no beats after release; a fresh packet then works.
6. Send 2-word packets back-to-back with a 1-cycle gap and random out_ready, 200 packets. Required: every word is delivered in order with correct sop/eop; pkt_count=200; no drops.
